factory_test_seq: RTL and testbench
===================================

FACTORY_TEST_SEQ -- requirements
Module: factory_test_seq

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, range 1..15: cycles each pattern is driven before it is compared.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low, sampled on the clk rising edge.
REQ-004 SHALL have port ena  input  1  clock enable; when 0 all registers hold their value.
REQ-005 SHALL have port ui_in  input  8  control: [0] start, [2:1] mode, [3] view select, [7] abort, [6:4] unused.
REQ-006 SHALL have port uo_out  output  8  status / error-count view.
REQ-007 SHALL have port uio_in  input  8  loopback sample of the bidirectional pads.
REQ-008 SHALL have port uio_out  output  8  test pattern driven to the pads.
REQ-009 SHALL have port uio_oe  output  8  pad output enable, 1 = drive.

Function
REQ-010 SHALL implement FSM states IDLE, SETTLE, CHECK, DONE.
REQ-011 SHALL register ui_in[0] into start_q each enabled cycle; start event = ui_in[0] & ~start_q.
REQ-012 SHALL, on start event in IDLE or DONE: latch mode = ui_in[2:1], clear step, err_cnt, aborted, settle counter; go to SETTLE.
REQ-013 SHALL ignore start events in SETTLE and CHECK; start held high SHALL produce only one run.
REQ-014 SHALL generate pattern from latched mode and 8-bit step index:
  - mode 0 walking-one: 1<<step, 8 steps.
  - mode 1 walking-zero: ~(1<<step), 8 steps.
  - mode 2 count-up: step, 256 steps.
  - mode 3 checkerboard: 0x55 on even step, 0xAA on odd, 16 steps.
REQ-015 SHALL stay in SETTLE for exactly SETTLE_CYCLES cycles, then enter CHECK for one cycle; each step = SETTLE_CYCLES+1 cycles.
REQ-016 SHALL drive uio_out = pattern and uio_oe = 0xFF in SETTLE and CHECK; uio_out = 0x00, uio_oe = 0x00 in IDLE and DONE.
REQ-017 SHALL in CHECK compare uio_in to pattern and increment err_cnt on mismatch.
REQ-018 SHALL saturate err_cnt at 255; it SHALL never wrap to 0.
REQ-019 SHALL in CHECK go to DONE if step is the last step of the mode, else increment step and return to SETTLE.
REQ-020 SHALL, when ui_in[7]=1 in SETTLE or CHECK, set aborted=1 and go to DONE; abort SHALL take priority over the compare in the same cycle (no err_cnt update).
REQ-021 SHALL ignore abort in IDLE and DONE.
REQ-022 SHALL define busy = state is SETTLE or CHECK; done = state is DONE; pass = done & ~aborted & (err_cnt == 0).
REQ-023 SHALL drive uo_out = {busy, done, pass, aborted, err_cnt[3:0]} when ui_in[3]=0, and uo_out = err_cnt[7:0] when ui_in[3]=1 (combinational select).
REQ-024 SHALL hold DONE with err_cnt and aborted until the next start event or reset.

Reset
REQ-025 SHALL, with rst_n=0 at a clk edge, set state=IDLE, step=0, err_cnt=0, aborted=0, start_q=0, mode=0, settle counter=0, regardless of ena.
REQ-026 SHALL, after reset, output uo_out=0x00 (either view), uio_out=0x00, uio_oe=0x00.
REQ-027 SHALL, on reset mid-run, abandon the run with no DONE state and release the pads (uio_oe=0x00) from the next edge.

Verification
REQ-028 Reset: rst_n=0 for 2 cycles during a run -> uo_out=0x00, uio_oe=0x00, uio_out=0x00.
REQ-029 Loopback pass: uio_in=uio_out, mode 0, SETTLE_CYCLES=2, start pulse -> uio_out steps 0x01..0x80, each for 3 cycles; DONE 24 cycles after the start edge; uo_out=0x60.
REQ-030 Stuck bit: uio_in=uio_out & 0xFE, mode 0 -> only step 0 fails; final uo_out=0x41.
REQ-031 Saturation: uio_in=~uio_out, mode 2, ui_in[3]=1 -> 256 mismatches; final uo_out=0xFF, no wrap.
REQ-032 Abort: mode 3, ui_in[7]=1 in the CHECK cycle of step 3 -> step 3 not counted; DONE next cycle; uo_out[7:4]=0101; uio_oe=0x00.
REQ-033 Start handling: ui_in[0] held high throughout a run, plus a second 0->1 pulse while busy -> exactly one run; a new start edge from DONE restarts with err_cnt=0.

Source files
------------

// File: rtl/factory_test_seq.sv
// factory_test_seq: pad loopback self-test that drives walking/count/checker patterns and counts mismatches
module factory_test_seq #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;
  state_e state_q;
  logic [1:0] mode_q;
  logic [7:0] step_q, err_q, pat_d, err_d, one_d;
  logic [3:0] cnt_q;
  logic start_q, aborted_q, start_ev, abort, busy, done, pass, last, unused_ok;
  always_comb begin
    one_d = 8'd1 << step_q[2:0];
    pat_d = mode_q == 2'd0 ? one_d :
            mode_q == 2'd1 ? ~one_d :
            mode_q == 2'd2 ? step_q :
            step_q[0] ? 8'hAA : 8'h55;
    last = mode_q == 2'd2 ? step_q == 8'hFF :
           mode_q == 2'd3 ? step_q == 8'd15 : step_q == 8'd7;
    err_d = (uio_in != pat_d && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end
  assign start_ev  = ui_in[0] & ~start_q;
  assign abort     = ui_in[7];
  assign busy      = state_q == SETTLE || state_q == CHECK;
  assign done      = state_q == DONE;
  assign pass      = done & ~aborted_q & (err_q == 8'd0);
  assign uio_out   = busy ? pat_d : 8'h00;
  assign uio_oe    = {8{busy}};
  assign uo_out    = ui_in[3] ? err_q : {busy, done, pass, aborted_q, err_q[3:0]};
  assign unused_ok = &{1'b0, ui_in[6:4]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= 2'd0;
      step_q    <= 8'd0;
      err_q     <= 8'd0;
      cnt_q     <= 4'd0;
      start_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else if (ena) begin
      start_q <= ui_in[0];
      case (state_q)
        SETTLE: begin
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= DONE;
          end else if (cnt_q == 4'(SETTLE_CYCLES - 1)) begin
            cnt_q   <= 4'd0;
            state_q <= CHECK;
          end else cnt_q <= cnt_q + 4'd1;
        end
        CHECK: begin
          // abort wins over the compare so the interrupted step is never counted
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            err_q <= err_d;
            if (last) state_q <= DONE;
            else begin
              step_q  <= step_q + 8'd1;
              state_q <= SETTLE;
            end
          end
        end
        default: begin
          if (start_ev) begin
            mode_q    <= ui_in[2:1];
            step_q    <= 8'd0;
            err_q     <= 8'd0;
            cnt_q     <= 4'd0;
            aborted_q <= 1'b0;
            state_q   <= SETTLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_factory_test_seq.sv
// tb_factory_test_seq: table-driven runs with a pad-pattern scoreboard plus reset/abort/start/enable sequences
module tb_factory_test_seq;
  localparam int SC = 2;
  logic clk = 1'b0, rst_n, ena;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
  logic [1:0] lb;
  int n_chk = 0, n_fail = 0;
  logic [7:0] sb[$];
  typedef struct {
    logic [1:0] mode;
    logic [1:0] lb;
    logic       view;
    logic [7:0] exp_uo;
    int         cycles;
  } vec_t;
  vec_t vt[9];

  factory_test_seq #(.SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;
  assign uio_in = lb == 2'd0 ? uio_out : lb == 2'd1 ? (uio_out & 8'hFE) : ~uio_out;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [1:0] m, input int s);
    logic [7:0] one;
    one = 8'h01 << (s % 8);
    case (m)
      2'd0: return one;
      2'd1: return ~one;
      2'd2: return 8'(s);
      default: return (s % 2) ? 8'hAA : 8'h55;
    endcase
  endfunction

  function automatic int nsteps(input logic [1:0] m);
    return m == 2'd2 ? 256 : m == 2'd3 ? 16 : 8;
  endfunction

  task automatic run(input vec_t v, input int idx);
    int n;
    lb = v.lb;
    ui_in = {4'b0, v.view, v.mode, 1'b0};
    @(negedge clk);
    ui_in[0] = 1'b1;
    for (int s = 0; s < nsteps(v.mode); s++)
      for (int k = 0; k <= SC; k++) sb.push_back(pat(v.mode, s));
    @(negedge clk);
    ui_in[0] = 1'b0;
    chk($sformatf("v%0d_restart_uo", idx), uo_out, v.view ? 8'h00 : 8'h80);
    n = 0;
    while (uio_oe == 8'hFF && n < 2000) begin
      if (sb.size() == 0) chk($sformatf("v%0d_sb_underflow", idx), 1, 0);
      else chk($sformatf("v%0d_pad", idx), uio_out, sb.pop_front());
      n++;
      @(negedge clk);
    end
    chk($sformatf("v%0d_cycles", idx), n, v.cycles);
    chk($sformatf("v%0d_sb_left", idx), sb.size(), 0);
    chk($sformatf("v%0d_uo", idx), uo_out, v.exp_uo);
    chk($sformatf("v%0d_oe_done", idx), uio_oe, 8'h00);
    chk($sformatf("v%0d_pad_done", idx), uio_out, 8'h00);
    sb.delete();
  endtask

  initial begin
    int n;
    vt[0] = '{2'd0, 2'd0, 1'b0, 8'h60, 24};
    vt[1] = '{2'd0, 2'd1, 1'b0, 8'h41, 24};
    vt[2] = '{2'd0, 2'd0, 1'b0, 8'h60, 24};
    vt[3] = '{2'd1, 2'd1, 1'b0, 8'h47, 24};
    vt[4] = '{2'd2, 2'd2, 1'b1, 8'hFF, 768};
    vt[5] = '{2'd3, 2'd1, 1'b0, 8'h48, 48};
    vt[6] = '{2'd3, 2'd2, 1'b1, 8'h10, 48};
    vt[7] = '{2'd2, 2'd1, 1'b0, 8'h40, 768};
    vt[8] = '{2'd1, 2'd0, 1'b1, 8'h00, 24};
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; lb = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_uo_v0", uo_out, 8'h00);
    chk("rst_oe", uio_oe, 8'h00);
    chk("rst_pad", uio_out, 8'h00);
    ui_in[3] = 1'b1;
    #1 chk("rst_uo_v1", uo_out, 8'h00);
    ui_in[3] = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) run(vt[i], i);

    // start held high with an extra edge mid-run; then clock-enable hold
    lb = 2'd0; ui_in = 8'h00;
    @(negedge clk);
    ui_in[0] = 1'b1;
    @(negedge clk);
    n = 0;
    while (uio_oe == 8'hFF && n < 200) begin
      n++;
      if (n == 5) ui_in[0] = 1'b0;
      if (n == 6) ui_in[0] = 1'b1;
      @(negedge clk);
    end
    chk("held_cycles", n, 24);
    chk("held_uo", uo_out, 8'h60);
    repeat (5) @(negedge clk);
    chk("held_no_rerun_oe", uio_oe, 8'h00);
    chk("held_no_rerun_uo", uo_out, 8'h60);
    ui_in[0] = 1'b0;
    @(negedge clk);
    ui_in[0] = 1'b1;
    @(negedge clk);
    ui_in[0] = 1'b0;
    n = 0;
    while (uio_oe == 8'hFF && n < 200) begin
      n++;
      if (n == 3) begin
        ena = 1'b0;
        repeat (5) @(negedge clk);
        chk("ena_hold_pad", uio_out, 8'h01);
        chk("ena_hold_uo", uo_out, 8'h80);
        ena = 1'b1;
      end
      @(negedge clk);
    end
    chk("ena_cycles", n, 24);
    chk("ena_uo", uo_out, 8'h60);

    // abort in the CHECK cycle of step 3 with every step mismatching
    lb = 2'd2; ui_in = 8'h06;
    @(negedge clk);
    ui_in[0] = 1'b1;
    @(negedge clk);
    ui_in[0] = 1'b0;
    n = 0;
    while (uio_oe == 8'hFF && n < 200) begin
      n++;
      if (n == 12) begin
        chk("abort_step3_pad", uio_out, 8'hAA);
        ui_in[7] = 1'b1;
      end
      @(negedge clk);
    end
    chk("abort_cycles", n, 12);
    chk("abort_uo", uo_out, 8'h53);
    chk("abort_oe", uio_oe, 8'h00);
    repeat (3) @(negedge clk);
    chk("abort_ignored_done", uo_out, 8'h53);
    ui_in[7] = 1'b0;

    // reset mid-run releases the pads and never reaches DONE
    lb = 2'd0; ui_in = 8'h04;
    @(negedge clk);
    ui_in[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrun_busy_oe", uio_oe, 8'hFF);
    rst_n = 1'b0; ui_in = 8'h00;
    @(negedge clk);
    chk("midrun_rst_oe_1", uio_oe, 8'h00);
    @(negedge clk);
    chk("midrun_rst_uo", uo_out, 8'h00);
    chk("midrun_rst_oe", uio_oe, 8'h00);
    chk("midrun_rst_pad", uio_out, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrun_idle_uo", uo_out, 8'h00);
    chk("midrun_idle_oe", uio_oe, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
